// File: rtl/inst_rom_loader_pkg.sv
// Shared constants for the instruction ROM loader: fetch NOP word,
// loader state encodings and the core reset level.
package inst_rom_loader_pkg;

   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic        RST_ASSERTED = 1'b0;

   typedef logic [1:0] ld_state_t;

   localparam ld_state_t LD_IDLE = 2'd0;
   localparam ld_state_t LD_LOAD = 2'd1;
   localparam ld_state_t LD_DONE = 2'd2;

   // Reset level driven to the core straight out of reset.
   function automatic logic boot_core_rst(input int boot_hold);
      return (boot_hold != 0) ? RST_ASSERTED : ~RST_ASSERTED;
   endfunction

endpackage

// File: rtl/inst_rom_loader_ld_word_pack.sv
// Byte-to-word packer: collects three little-endian byte lanes and
// presents the full word on the beat that supplies the fourth byte.
module ld_word_pack
   import inst_rom_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic        i_beat,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word_data
);

   logic [1:0]  r_byte_cnt;
   // Lane 3 never needs storage: it is taken directly from the bus.
   logic [23:0] r_asm;

   // Word completion strobe and assembled word.
   always_comb begin
      o_word_valid = i_beat && (r_byte_cnt == 2'd3);
      o_word_data  = {i_byte, r_asm};
   end

   // Byte counter and lane storage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_byte_cnt <= 2'd0;
         r_asm      <= 24'h00_0000;
      end else if (i_clr) begin
         r_byte_cnt <= 2'd0;
         r_asm      <= 24'h00_0000;
      end else if (i_beat) begin
         case (r_byte_cnt)
            2'd0:    r_asm[7:0]   <= i_byte;
            2'd1:    r_asm[15:8]  <= i_byte;
            2'd2:    r_asm[23:16] <= i_byte;
            default: r_asm        <= 24'h00_0000;
         endcase
         r_byte_cnt <= r_byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial run-time load port; keeps the core in
// reset while an image is written and answers fetches combinationally.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int BOOT_HOLD  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start_i,
   input  logic [ADDR_WIDTH:0]   ld_len_i,
   input  logic                  ld_valid_i,
   input  logic [7:0]            ld_byte_i,
   output logic                  ld_ready_o,
   output logic                  ld_busy_o,
   output logic                  ld_done_o,
   output logic                  ld_err_o,
   output logic                  core_rst_o
);

   localparam int                  DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   ld_state_t             r_state;
   ld_state_t             w_state_nxt;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_word_cnt;
   logic [ADDR_WIDTH:0]   w_word_cnt_inc;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic                  r_core_rst;
   logic                  w_len_ok;
   logic                  w_accept;
   logic                  w_beat;
   logic                  w_word_valid;
   logic [31:0]           w_word_data;
   logic                  w_addr_in_range;
   logic                  w_unused_addr;
   logic [31:0]           r_mem [0:DEPTH-1];

   assign ld_ready_o    = r_ready;
   assign ld_busy_o     = r_busy;
   assign ld_done_o     = r_done;
   assign ld_err_o      = r_err;
   assign core_rst_o    = r_core_rst;
   assign w_unused_addr = ^rom_addr_i[1:0];

   // Request qualification and load-port handshake.
   always_comb begin
      w_len_ok       = (ld_len_i != LEN_ZERO) && (ld_len_i <= DEPTH_LEN);
      w_accept       = (r_state == LD_IDLE) && ld_start_i && w_len_ok;
      w_beat         = ld_valid_i && r_ready;
      w_word_cnt_inc = r_word_cnt + LEN_ONE;
   end

   ld_word_pack u_pack (
      .i_clk        (clk),
      .i_rst_n      (rst),
      .i_clr        (w_accept),
      .i_beat       (w_beat),
      .i_byte       (ld_byte_i),
      .o_word_valid (w_word_valid),
      .o_word_data  (w_word_data)
   );

   // Loader next-state decode.
   always_comb begin
      w_state_nxt = LD_IDLE;
      case (r_state)
         LD_IDLE: begin
            if (w_accept) w_state_nxt = LD_LOAD;
            else          w_state_nxt = LD_IDLE;
         end
         LD_LOAD: begin
            if (w_word_valid && (w_word_cnt_inc == r_len)) w_state_nxt = LD_DONE;
            else                                           w_state_nxt = LD_LOAD;
         end
         LD_DONE: w_state_nxt = LD_IDLE;
         default: w_state_nxt = LD_IDLE;
      endcase
   end

   // State, status outputs and word counter; outputs follow the next state
   // so ready drops on the same edge that accepts the final byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LD_IDLE;
         r_len      <= LEN_ZERO;
         r_word_cnt <= LEN_ZERO;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_core_rst <= boot_core_rst(BOOT_HOLD);
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == LD_LOAD);
         r_busy  <= (w_state_nxt == LD_LOAD) || (w_state_nxt == LD_DONE);
         r_done  <= (w_state_nxt == LD_DONE);
         if (w_accept) begin
            r_len      <= ld_len_i;
            r_word_cnt <= LEN_ZERO;
            r_err      <= 1'b0;
            r_core_rst <= RST_ASSERTED;
         end else if ((r_state == LD_IDLE) && ld_start_i) begin
            r_err <= 1'b1;
         end else if (r_state == LD_DONE) begin
            r_core_rst <= ~RST_ASSERTED;
         end else if (w_word_valid) begin
            r_word_cnt <= w_word_cnt_inc;
         end
      end
   end

   // Word storage; deliberately not reset so images survive a mid-load reset.
   always_ff @(posedge clk) begin
      if (w_word_valid) begin
         r_mem[r_word_cnt[ADDR_WIDTH-1:0]] <= w_word_data;
      end
   end

   // Zero-latency fetch; NOP while loading, disabled or out of range.
   always_comb begin
      w_addr_in_range = (rom_addr_i[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
      rom_data_o      = ZERO_WORD;
      if (rom_ce_i && (r_state == LD_IDLE) && w_addr_in_range) begin
         rom_data_o = r_mem[rom_addr_i[ADDR_WIDTH+1:2]];
      end else begin
         rom_data_o = ZERO_WORD;
      end
   end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed + randomized bench for inst_rom_loader with a word-level
// reference image of the ROM contents.
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        ld_start_i;
   logic [10:0] ld_len_i;
   logic        ld_valid_i;
   logic [7:0]  ld_byte_i;
   logic        ld_ready_o;
   logic        ld_busy_o;
   logic        ld_done_o;
   logic        ld_err_o;
   logic        core_rst_o;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int cyc     = 0;

   logic [31:0] img     [0:1023];
   logic [31:0] ref_mem [0:1023];

   inst_rom_loader #(.ADDR_WIDTH(10), .BOOT_HOLD(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .ld_start_i (ld_start_i),
      .ld_len_i   (ld_len_i),
      .ld_valid_i (ld_valid_i),
      .ld_byte_i  (ld_byte_i),
      .ld_ready_o (ld_ready_o),
      .ld_busy_o  (ld_busy_o),
      .ld_done_o  (ld_done_o),
      .ld_err_o   (ld_err_o),
      .core_rst_o (core_rst_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch_check(input string tag, input int unsigned addr, input logic [31:0] exp);
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'(addr);
      #1;
      check(tag, rom_data_o, exp);
   endtask

   // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid.
   // abort_at > 0 stops feeding after that many accepted bytes.
   task automatic run_load(input int nw, input int mode, input int abort_at,
                           output int first_cyc, output int done_cyc);
      int   nb;
      int   idx;
      int   budget;
      int   a;
      logic v;
      logic phase;
      nb        = nw * 4;
      idx       = 0;
      budget    = 0;
      phase     = 1'b1;
      first_cyc = -1;
      done_cyc  = -1;
      ld_len_i   = 11'(nw);
      ld_start_i = 1'b1;
      tick();
      ld_start_i = 1'b0;
      check("start_err_clr", 32'(ld_err_o), 32'd0);
      check("start_core_rst", 32'(core_rst_o), 32'd0);
      check("start_busy", 32'(ld_busy_o), 32'd1);
      check("start_ready", 32'(ld_ready_o), 32'd1);
      while (idx < nb && !(abort_at > 0 && idx == abort_at) && budget < 20 * nb + 40) begin
         if (mode == 0)      v = 1'b1;
         else if (mode == 1) v = phase;
         else                v = 1'($urandom_range(0, 1));
         phase = ~phase;
         a = $urandom_range(0, 1023);
         ld_valid_i = v;
         ld_byte_i  = img[idx / 4][8 * (idx % 4) +: 8];
         fetch_check("load_fetch_nop", 32'(a) << 2, 32'h0);
         if (v && ld_ready_o) begin
            if (first_cyc < 0) first_cyc = cyc;
            idx++;
         end
         tick();
         budget++;
      end
      ld_valid_i = 1'b0;
      if (abort_at > 0) begin
         check("abort_bytes", 32'(idx), 32'(abort_at));
         for (int w = 0; w < idx / 4; w++) ref_mem[w] = img[w];
      end else begin
         check("load_bytes", 32'(idx), 32'(nb));
         check("done_pulse", 32'(ld_done_o), 32'd1);
         check("done_ready", 32'(ld_ready_o), 32'd0);
         check("done_busy", 32'(ld_busy_o), 32'd1);
         fetch_check("done_fetch_nop", 32'h0, 32'h0);
         done_cyc = cyc;
         tick();
         check("post_done", 32'(ld_done_o), 32'd0);
         check("post_core_rst", 32'(core_rst_o), 32'd1);
         check("post_busy", 32'(ld_busy_o), 32'd0);
         for (int w = 0; w < nw; w++) ref_mem[w] = img[w];
      end
   endtask

   task automatic bad_start(input logic [10:0] len, input string tag);
      ld_len_i   = len;
      ld_start_i = 1'b1;
      tick();
      ld_start_i = 1'b0;
      check({tag, "_err"}, 32'(ld_err_o), 32'd1);
      check({tag, "_ready"}, 32'(ld_ready_o), 32'd0);
      check({tag, "_busy"}, 32'(ld_busy_o), 32'd0);
      check({tag, "_core_rst"}, 32'(core_rst_o), 32'd1);
      fetch_check({tag, "_idle_fetch"}, 32'h4, ref_mem[1]);
   endtask

   initial begin
      int fc;
      int dc;
      int nw;
      int w;
      int off;
      rst        = 1'b0;
      rom_ce_i   = 1'b0;
      rom_addr_i = 32'h0;
      ld_start_i = 1'b0;
      ld_len_i   = 11'd0;
      ld_valid_i = 1'b0;
      ld_byte_i  = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("rst_core_rst", 32'(core_rst_o), 32'd0);
      check("rst_ready", 32'(ld_ready_o), 32'd0);
      check("rst_busy", 32'(ld_busy_o), 32'd0);
      check("rst_done", 32'(ld_done_o), 32'd0);
      check("rst_err", 32'(ld_err_o), 32'd0);
      rom_ce_i = 1'b0;
      #1;
      check("rst_fetch_ce0", rom_data_o, 32'h0);
      fetch_check("rst_fetch_oob", 32'h0000_1000, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Directed image from the bring-up program.
      img[0] = 32'h3401_0013;
      img[1] = 32'hFFFF_0824;
      run_load(2, 0, 0, fc, dc);
      fetch_check("dir_w0", 32'h0, 32'h3401_0013);
      fetch_check("dir_w1", 32'h4, 32'hFFFF_0824);
      fetch_check("dir_w1_lowbits", 32'h7, 32'hFFFF_0824);

      for (int i = 0; i < 2; i++) ref_mem[i] = 32'h0;
      run_load(2, 1, 0, fc, dc);
      check("toggle_done_span", 32'(dc - fc + 1), 32'd16);
      fetch_check("tog_w0", 32'h0, 32'h3401_0013);
      fetch_check("tog_w1", 32'h4, 32'hFFFF_0824);

      bad_start(11'd0, "len0");
      bad_start(11'd1025, "len1025");

      for (int i = 0; i < 1024; i++) img[i] = $urandom;
      run_load(1024, 0, 0, fc, dc);
      fetch_check("full_last", 32'h0000_0FFC, ref_mem[1023]);
      fetch_check("full_first", 32'h0, ref_mem[0]);
      fetch_check("full_oob", 32'h0000_1000, 32'h0);
      fetch_check("full_oob_hi", 32'h8000_0000, 32'h0);

      for (int r = 0; r < 3; r++) begin
         nw = $urandom_range(1, 8);
         for (int i = 0; i < nw; i++) img[i] = $urandom;
         run_load(nw, 2, 0, fc, dc);
         for (int k = 0; k < 6; k++) begin
            w   = $urandom_range(0, nw + 3);
            off = $urandom_range(0, 3);
            fetch_check("rand_fetch", 32'(w * 4 + off), ref_mem[w]);
         end
      end

      // Reset after five bytes of a two-word load.
      img[0] = 32'hCAFE_F00D;
      img[1] = 32'h1234_5678;
      run_load(2, 0, 5, fc, dc);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(ld_ready_o), 32'd0);
      check("mid_rst_busy", 32'(ld_busy_o), 32'd0);
      check("mid_rst_done", 32'(ld_done_o), 32'd0);
      check("mid_rst_err", 32'(ld_err_o), 32'd0);
      check("mid_rst_core_rst", 32'(core_rst_o), 32'd0);
      fetch_check("mid_rst_w0", 32'h0, ref_mem[0]);
      fetch_check("mid_rst_w1", 32'h4, ref_mem[1]);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("mid_rst_hold", 32'(core_rst_o), 32'd0);
      run_load(2, 0, 0, fc, dc);
      fetch_check("reload_w0", 32'h0, 32'hCAFE_F00D);
      fetch_check("reload_w1", 32'h4, 32'h1234_5678);

      rom_ce_i = 1'b0;
      #1;
      check("ce0_nop", rom_data_o, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
